// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch sequencer.
package fetch_ctrl_pkg;
    localparam int          XLEN       = 32;
    localparam logic [31:0] BOOT_ADDR  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: DEPTH x {inst, pc} FIFO with sync clear; head is read straight from flops.
module fetch_ibuf #(
    parameter int XLEN  = fetch_ctrl_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [31:0]              i_inst,
    input  logic [XLEN-1:0]          i_pc,
    input  logic                     i_pop,
    output logic [31:0]              o_inst,
    output logic [XLEN-1:0]          o_pc,
    output logic [$clog2(DEPTH):0]   o_count
);
    import fetch_ctrl_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [31:0]     r_inst [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [PW:0]     r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_inst[r_wr] <= i_inst;
                r_pc[r_wr]   <= i_pc;
                r_wr         <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_inst  = r_inst[r_rd];
    assign o_pc    = r_pc[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time, steers via the predictor.
module fetch_ctrl #(
    parameter int              XLEN       = fetch_ctrl_pkg::XLEN,
    parameter logic [XLEN-1:0] BOOT_ADDR  = fetch_ctrl_pkg::BOOT_ADDR,
    parameter int              IBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] bp_pc_o,
    output logic [31:0]     bp_inst_o,
    input  logic [XLEN-1:0] bp_next_pc_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
);
    import fetch_ctrl_pkg::*;

    localparam int CW = $clog2(IBUF_DEPTH) + 1;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_q;
    logic            r_req_en;
    logic [CW-1:0]   w_count;
    logic            w_req_ok;
    logic            w_push;
    logic            w_pop;

    // r_req_en keeps the request low during reset and for the cycle in which reset is released.
    assign w_req_ok     = r_req_en && (r_state == ST_REQ) && (w_count < CW'(IBUF_DEPTH));
    assign imem_req_o   = w_req_ok && !flush_i;
    assign imem_addr_o  = r_pc;
    assign bp_pc_o      = r_pc_q;
    assign bp_inst_o    = imem_rdata_i;
    assign w_push       = (r_state == ST_WAIT) && imem_rvalid_i && !flush_i;
    assign inst_valid_o = (w_count != '0) && !flush_i;
    assign w_pop        = inst_valid_o && inst_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state  <= ST_REQ;
            r_pc     <= BOOT_ADDR;
            r_pc_q   <= '0;
            r_req_en <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            if (flush_i) begin
                r_pc <= flush_addr_i;
                // A grant racing the flush still owes us a response, which must be dropped.
                case (r_state)
                    ST_REQ:  if (imem_gnt_i && w_req_ok) r_state <= ST_DROP;
                    ST_WAIT: r_state <= imem_rvalid_i ? ST_REQ : ST_DROP;
                    ST_DROP: if (imem_rvalid_i) r_state <= ST_REQ;
                    default: r_state <= ST_REQ;
                endcase
            end else begin
                case (r_state)
                    ST_REQ: begin
                        if (imem_req_o && imem_gnt_i) begin
                            r_pc_q  <= r_pc;
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid_i) begin
                            r_pc    <= bp_next_pc_i;
                            r_state <= ST_REQ;
                        end
                    end
                    ST_DROP: if (imem_rvalid_i) r_state <= ST_REQ;
                    default: r_state <= ST_REQ;
                endcase
            end
        end
    end

    fetch_ibuf #(
        .XLEN  (XLEN),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush_i),
        .i_push  (w_push),
        .i_inst  (imem_rdata_i),
        .i_pc    (r_pc_q),
        .i_pop   (w_pop),
        .o_inst  (inst_o),
        .o_pc    (inst_pc_o),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: zero-wait memory, +4/jal predictor, backpressure, flush and reset.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] bp_pc_o;
    logic [31:0] bp_inst_o;
    logic [31:0] bp_next_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    logic [31:0] jal_pc  = 32'hFFFF_FFFF;
    logic [31:0] jal_tgt = 32'h0;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Static predictor model: +4 unless the returning PC is the marked jal.
    assign bp_next_pc_i = (bp_pc_o == jal_pc) ? jal_tgt : bp_pc_o + 32'd4;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .bp_pc_o       (bp_pc_o),
        .bp_inst_o     (bp_inst_o),
        .bp_next_pc_i  (bp_next_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic v, input logic [31:0] pc);
        chk("head_valid", inst_valid_o, v);
        if (v) begin
            chk("head_pc", inst_pc_o, pc);
            chk("head_inst", inst_o, inst_of(pc));
        end
    endtask

    // One zero-wait fetch: grant now, response next cycle, returns settled in the following cycle.
    task automatic fetch(input logic [31:0] a);
        chk("req", imem_req_o, 1);
        chk("addr", imem_addr_o, a);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(a);
        #1;
        chk("bp_pc", bp_pc_o, a);
        chk("bp_inst", bp_inst_o, inst_of(a));
        chk("wait_req", imem_req_o, 0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        flush_i       = 1'b0;
        flush_addr_i  = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        inst_ready_i  = 1'b1;
        #3;
        chk("rst_req", imem_req_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_inst_pc", inst_pc_o, 0);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_bp_pc", bp_pc_o, 0);
        tick();
        rst = 1'b0;
        tick();
        #1;

        // Sequential fetch with a jal at 0x8 redirecting to 0x100.
        jal_pc  = 32'h8;
        jal_tgt = 32'h100;
        fetch(32'h0);
        head(1'b1, 32'h0);
        fetch(32'h4);
        head(1'b1, 32'h4);
        fetch(32'h8);
        head(1'b1, 32'h8);
        chk("jal_addr", imem_addr_o, 32'h100);
        tick();
        head(1'b0, 32'h0);

        // Backpressure: two entries fill the buffer and stall requests.
        inst_ready_i = 1'b0;
        fetch(32'h100);
        head(1'b1, 32'h100);
        fetch(32'h104);
        head(1'b1, 32'h100);
        chk("full_req", imem_req_o, 0);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #1;
        chk("stray_gnt_req", imem_req_o, 0);
        chk("stray_gnt_bp", bp_pc_o, 32'h104);
        head(1'b1, 32'h100);
        inst_ready_i = 1'b1;
        #1;
        tick();
        head(1'b1, 32'h104);
        chk("resume_req", imem_req_o, 1);
        tick();
        head(1'b0, 32'h0);
        fetch(32'h108);
        head(1'b1, 32'h108);

        // Flush while waiting; the late response must vanish.
        inst_ready_i = 1'b0;
        chk("pre_flush_addr", imem_addr_o, 32'h10C);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i   = 1'b0;
        flush_i      = 1'b1;
        flush_addr_i = 32'h200;
        #1;
        chk("flush_valid", inst_valid_o, 0);
        chk("flush_req", imem_req_o, 0);
        tick();
        flush_i = 1'b0;
        #1;
        head(1'b0, 32'h0);
        chk("drop_req", imem_req_o, 0);
        chk("drop_addr", imem_addr_o, 32'h200);
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(32'h10C);
        #1;
        chk("drop_rv_req", imem_req_o, 0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        head(1'b0, 32'h0);
        inst_ready_i = 1'b1;
        fetch(32'h200);
        head(1'b1, 32'h200);

        // Flush in the same cycle as the response.
        chk("req_204", imem_req_o, 1);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(32'h204);
        flush_i       = 1'b1;
        flush_addr_i  = 32'h300;
        #1;
        chk("flush_rv_valid", inst_valid_o, 0);
        tick();
        imem_rvalid_i = 1'b0;
        flush_i       = 1'b0;
        #1;
        chk("post_flush_req", imem_req_o, 1);
        chk("post_flush_addr", imem_addr_o, 32'h300);
        head(1'b0, 32'h0);
        fetch(32'h300);
        head(1'b1, 32'h300);

        // Reset while waiting with one buffered entry.
        inst_ready_i = 1'b0;
        imem_gnt_i   = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst        = 1'b1;
        #1;
        chk("mid_rst_valid", inst_valid_o, 0);
        chk("mid_rst_inst", inst_o, 0);
        chk("mid_rst_inst_pc", inst_pc_o, 0);
        chk("mid_rst_req", imem_req_o, 0);
        chk("mid_rst_addr", imem_addr_o, 0);
        chk("mid_rst_bp_pc", bp_pc_o, 0);
        tick();
        rst           = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(32'h304);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        head(1'b0, 32'h0);
        chk("restart_req", imem_req_o, 1);
        chk("restart_addr", imem_addr_o, 0);
        inst_ready_i = 1'b1;
        fetch(32'h0);
        head(1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the PC/static-branch-predictor path and a single-port instruction memory. It owns the fetch PC and issues one instruction request at a time using a req/gnt/rvalid handshake. It routes each returned instruction through the predictor to select the next fetch address, and buffers fetched instructions for the decode stage. It also handles pipeline flush (redirect), which discards in-flight responses, and backpressure from decode.

## Interface
Parameters:
- XLEN, 32, address/data width
- BOOT_ADDR, 32'h0000_0000, fetch PC after reset
- IBUF_DEPTH, 2, instruction buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  redirect request from execute/commit
- flush_addr_i  in  XLEN  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address (= fetch PC)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  32  response instruction
- bp_pc_o  out  XLEN  PC of the returning instruction, to predictor
- bp_inst_o  out  32  returning instruction, to predictor (= imem_rdata_i)
- bp_next_pc_i  in  XLEN  predicted next PC, combinational from bp_pc_o/bp_inst_o
- inst_valid_o  out  1  buffer head valid
- inst_o  out  32  buffer head instruction
- inst_pc_o  out  XLEN  buffer head PC
- inst_ready_i  in  1  decode accepts head

## Operation
- Registers: fetch PC `pc`, in-flight PC `pc_q`, state, buffer, count.
- FSM states: REQ, WAIT, DROP.
- REQ: imem_req_o = (count < IBUF_DEPTH) && !flush_i. If imem_gnt_i is high, set pc_q <= pc and go to WAIT. A gnt without req is ignored.
- WAIT: imem_req_o = 0. On imem_rvalid_i, push {imem_rdata_i, pc_q}, set pc <= bp_next_pc_i, and go to REQ.
- DROP: imem_req_o = 0. On imem_rvalid_i, discard the data and go to REQ. pc is unchanged.
- Flush (highest priority):
  - Clear the buffer.
  - pc <= flush_addr_i.
  - From REQ: stay in REQ. If gnt arrives in the same cycle (possible only if req was already high before flush), go to DROP.
  - From WAIT: go to REQ if imem_rvalid_i is high in the same cycle (response dropped), otherwise go to DROP.
  - From DROP: stay in DROP, unless rvalid is high in the same cycle, then go to REQ.
- inst_valid_o is forced to 0 while flush_i is high, so no handoff happens in the flush cycle.
- Buffer: FIFO with registered head outputs. A pop occurs when inst_valid_o && inst_ready_i. Push and pop may occur in the same cycle.
- Full is impossible at push time: a request is issued only while count < IBUF_DEPTH, and only one request is outstanding.
- imem_rvalid_i in state REQ is a protocol error and is ignored.
- bp_pc_o = pc_q in every state. imem_addr_o = pc.
- Arithmetic: the pointers are log2(IBUF_DEPTH) bits and wrap modulo depth. count is log2(IBUF_DEPTH)+1 bits. The PC is never incremented locally; the predictor supplies +4 or the target.

## Timing
- Reset values:
  - pc = BOOT_ADDR, pc_q = 0, state = REQ, count = 0.
  - inst_valid_o = 0, inst_o = 0, inst_pc_o = 0.
  - imem_req_o = 1 one cycle after reset deassertion; its combinational value during reset is 0.
- Reset mid-operation returns to these values immediately. A response arriving after reset is ignored, because state is REQ.
- Latency with zero-wait memory (gnt in cycle t, rvalid at t+1): inst_valid_o rises at t+2. The next request is issued at t+2.
- Peak throughput is 1 instruction per 2 cycles.
- Flush at cycle t: the first request to flush_addr_i is issued at t+1 if no response is outstanding; otherwise it is issued in the cycle after the discarded rvalid.

## Structure
- Shared package:
  - XLEN
  - BOOT_ADDR default
  - RST_ENABLE
  - fetch state encoding (REQ/WAIT/DROP)
  - NOP encoding 32'h0000_0013
- Sub-module `fetch_ibuf`: synchronous FIFO (IBUF_DEPTH × {32-bit inst, XLEN PC}) with push, pop, synchronous clear, and count.
- fetch_ctrl contains the FSM, PC registers, and predictor glue.

## Test plan
- Reset, then memory with gnt=1 and rvalid one cycle later, predictor returning PC+4, ready=1 → requests at 0x0, 0x4, 0x8. inst_pc_o follows the same sequence, with the first valid at cycle 2.
- inst_ready_i=0 → after 2 instructions, count=2 and imem_req_o stays 0. Raising ready → one pop per cycle and requests resume.
- Predictor returns 0x100 for the instruction at 0x8 (jal) → the next imem_addr_o is 0x100 and no fetch is issued at 0xC.
- flush_i with flush_addr_i=0x200 while in WAIT, rvalid two cycles later → the buffer empties, the late instruction is never delivered, and the next request is to 0x200.
- flush_i in the same cycle as rvalid → the response is dropped, the FSM is in REQ next cycle, the request goes to the flush address, and inst_valid_o=0 during the flush cycle.
- Assert rst during WAIT with 1 buffered entry → all outputs return to their reset values, the stray rvalid is ignored, and fetch restarts at BOOT_ADDR.
